// File: rtl/rs_issue_select.sv
// rs_issue_select: picks up to N operand-ready RS entries per cycle in
// round-robin order. The picks go into N per-lane issue registers that hand
// packets to the functional units with a valid/ready handshake.

package rs_issue_pkg;
  localparam int B_MASK_W  = 4;
  localparam int PAYLOAD_W = 8;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [B_MASK_W-1:0]  b_mask;
    logic                 src1_ready;
    logic                 src2_ready;
  } rs_packet_t;
endpackage

// One issue lane: a holding register in front of one functional unit.
module rs_issue_lane
  import rs_issue_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                grant,
  input  rs_packet_t          grant_pkt,
  input  logic [B_MASK_W-1:0] b_mm_resolve,
  input  logic                b_mm_mispred,
  input  logic                fu_ready,
  output logic                free,
  output logic                accept,
  output logic                valid,
  output rs_packet_t          packet
);
  logic       valid_d, valid_q;
  rs_packet_t packet_d, packet_q;
  logic       squash;

  // Lane status. A squashed lane can take a new packet right away and does not count as accepted.
  always_comb begin
    squash = valid_q & b_mm_mispred & (|(packet_q.b_mask & b_mm_resolve));
    accept = valid_q & fu_ready & ~squash;
    free   = ~valid_q | fu_ready | squash;
  end

  // Next state: a new grant wins, then squash or accept clears the lane, otherwise hold and clear resolved mask bits.
  always_comb begin
    valid_d  = valid_q;
    packet_d = packet_q;
    packet_d.b_mask = packet_q.b_mask & ~b_mm_resolve;
    if (grant) begin
      valid_d  = 1'b1;
      packet_d = grant_pkt;
      packet_d.b_mask = grant_pkt.b_mask & ~b_mm_resolve;
    end else if (valid_q & (squash | fu_ready)) begin
      valid_d  = 1'b0;
      packet_d = '0;
    end
  end

  // Lane registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q  <= 1'b0;
      packet_q <= '0;
    end else begin
      valid_q  <= valid_d;
      packet_q <= packet_d;
    end
  end

  assign valid  = valid_q;
  assign packet = packet_q;
endmodule

module rs_issue_select
  import rs_issue_pkg::*;
#(
  parameter int N     = 2,
  parameter int RS_SZ = 8,
  parameter int CNT_W = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  rs_packet_t [RS_SZ-1:0]  rs_data_next,
  input  logic [RS_SZ-1:0]        rs_valid_issue,
  output logic [RS_SZ-1:0]        rs_data_issuing,
  input  logic [B_MASK_W-1:0]     b_mm_resolve,
  input  logic                    b_mm_mispred,
  input  logic [N-1:0]            fu_ready,
  output logic [N-1:0]            issue_valid,
  output rs_packet_t [N-1:0]      issue_packet,
  output logic [CNT_W-1:0]        issued_count
);
  localparam int PTR_W  = (RS_SZ > 1) ? $clog2(RS_SZ) : 1;
  localparam int LANE_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0]       rr_ptr_d, rr_ptr_q;
  logic [CNT_W-1:0]       issued_count_d, issued_count_q;
  logic [RS_SZ-1:0]       eligible;
  logic [N-1:0]           lane_free, lane_accept, lane_grant;
  rs_packet_t [N-1:0]     lane_pkt;
  logic [LANE_W-1:0]      free_idx [N];
  int                     nfree, ngrant, idx;

  // An entry can go only if it is valid and both of its operands are ready.
  always_comb begin
    for (int j = 0; j < RS_SZ; j++)
      eligible[j] = rs_valid_issue[j] & rs_data_next[j].src1_ready & rs_data_next[j].src2_ready;
  end

  // Round-robin scan from rr_ptr. The m-th eligible entry goes to the m-th free lane.
  always_comb begin
    rs_data_issuing = '0;
    lane_grant      = '0;
    lane_pkt        = '0;
    rr_ptr_d        = rr_ptr_q;
    nfree           = 0;
    ngrant          = 0;
    idx             = 0;
    for (int k = 0; k < N; k++) free_idx[k] = '0;
    for (int k = 0; k < N; k++) begin
      if (lane_free[k]) begin
        free_idx[nfree] = LANE_W'(k);
        nfree = nfree + 1;
      end
    end
    if (!reset) begin
      for (int i = 0; i < RS_SZ; i++) begin
        idx = (int'(rr_ptr_q) + i) % RS_SZ;
        if (eligible[idx] && (ngrant < nfree)) begin
          rs_data_issuing[idx]       = 1'b1;
          lane_grant[free_idx[ngrant]] = 1'b1;
          lane_pkt[free_idx[ngrant]]   = rs_data_next[idx];
          rr_ptr_d = PTR_W'((idx + 1) % RS_SZ);
          ngrant = ngrant + 1;
        end
      end
    end
  end

  // Count the packets the FUs accepted this cycle. Squashed packets are not counted.
  always_comb begin
    issued_count_d = issued_count_q;
    for (int k = 0; k < N; k++)
      if (lane_accept[k]) issued_count_d = issued_count_d + CNT_W'(1);
  end

  // Pointer and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q       <= '0;
      issued_count_q <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      issued_count_q <= issued_count_d;
    end
  end

  assign issued_count = issued_count_q;

  for (genvar k = 0; k < N; k++) begin : g_lane
    rs_issue_lane u_lane (
      .clock        (clock),
      .reset        (reset),
      .grant        (lane_grant[k]),
      .grant_pkt    (lane_pkt[k]),
      .b_mm_resolve (b_mm_resolve),
      .b_mm_mispred (b_mm_mispred),
      .fu_ready     (fu_ready[k]),
      .free         (lane_free[k]),
      .accept       (lane_accept[k]),
      .valid        (issue_valid[k]),
      .packet       (issue_packet[k])
    );
  end
endmodule

// File: tb/tb_rs_issue_select.sv
// Bench for rs_issue_select (N=2, RS_SZ=8). A queue-based reference model is
// compared against the DUT every cycle, and literal expectations pin the
// directed scenarios.
module tb_rs_issue_select;
  import rs_issue_pkg::*;
  localparam int N = 2;
  localparam int RS_SZ = 8;
  localparam int CNT_W = 16;

  logic                   clock = 1'b0;
  logic                   reset;
  rs_packet_t [RS_SZ-1:0] rs_data_next;
  logic [RS_SZ-1:0]       rs_valid_issue;
  logic [RS_SZ-1:0]       rs_data_issuing;
  logic [B_MASK_W-1:0]    b_mm_resolve;
  logic                   b_mm_mispred;
  logic [N-1:0]           fu_ready;
  logic [N-1:0]           issue_valid;
  rs_packet_t [N-1:0]     issue_packet;
  logic [CNT_W-1:0]       issued_count;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;
  logic [B_MASK_W-1:0] bm [RS_SZ];

  // reference model state
  logic [N-1:0]     m_valid = '0;
  rs_packet_t       m_pkt [N];
  int               m_ptr = 0;
  logic [CNT_W-1:0] m_cnt = '0;

  rs_issue_select #(.N(N), .RS_SZ(RS_SZ), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .rs_data_next(rs_data_next),
    .rs_valid_issue(rs_valid_issue), .rs_data_issuing(rs_data_issuing),
    .b_mm_resolve(b_mm_resolve), .b_mm_mispred(b_mm_mispred),
    .fu_ready(fu_ready), .issue_valid(issue_valid),
    .issue_packet(issue_packet), .issued_count(issued_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic lane_sq(input int k);
    return m_valid[k] && b_mm_mispred && (|(m_pkt[k].b_mask & b_mm_resolve));
  endfunction

  // Reference selection. Build a list of eligible entries in scan order and a
  // list of free lanes, then pair the two lists off.
  function automatic void model_select(output logic [RS_SZ-1:0] g,
                                       output logic [RS_SZ-1:0][3:0] lane_of,
                                       output int last);
    int eq[$];
    int fq[$];
    int e, l;
    g = '0; lane_of = '0; last = -1;
    for (int i = 0; i < RS_SZ; i++) begin
      e = (m_ptr + i) % RS_SZ;
      if (rs_valid_issue[e] && rs_data_next[e].src1_ready && rs_data_next[e].src2_ready)
        eq.push_back(e);
    end
    for (int k = 0; k < N; k++)
      if (!m_valid[k] || fu_ready[k] || lane_sq(k)) fq.push_back(k);
    if (!reset) begin
      while (eq.size() > 0 && fq.size() > 0) begin
        e = eq.pop_front();
        l = fq.pop_front();
        g[e] = 1'b1;
        lane_of[e] = 4'(l);
        last = e;
      end
    end
  endfunction

  // Advance the model on each clock edge.
  always @(posedge clock) begin
    logic [RS_SZ-1:0] g;
    logic [RS_SZ-1:0][3:0] lo;
    int last;
    logic [N-1:0] sq;
    if (reset) begin
      m_valid = '0;
      for (int k = 0; k < N; k++) m_pkt[k] = '0;
      m_ptr = 0;
      m_cnt = '0;
    end else begin
      model_select(g, lo, last);
      for (int k = 0; k < N; k++) sq[k] = lane_sq(k);
      for (int k = 0; k < N; k++)
        if (m_valid[k] && fu_ready[k] && !sq[k]) m_cnt = m_cnt + 1'b1;
      for (int k = 0; k < N; k++) begin
        if (m_valid[k] && (sq[k] || fu_ready[k])) begin
          m_valid[k] = 1'b0;
          m_pkt[k] = '0;
        end else begin
          m_pkt[k].b_mask = m_pkt[k].b_mask & ~b_mm_resolve;
        end
      end
      for (int e = 0; e < RS_SZ; e++) begin
        if (g[e]) begin
          m_pkt[int'(lo[e])] = rs_data_next[e];
          m_pkt[int'(lo[e])].b_mask = rs_data_next[e].b_mask & ~b_mm_resolve;
          m_valid[int'(lo[e])] = 1'b1;
        end
      end
      if (last >= 0) m_ptr = (last + 1) % RS_SZ;
    end
  end

  // Compare the DUT with the model on every falling edge.
  always @(negedge clock) begin
    logic [RS_SZ-1:0] g;
    logic [RS_SZ-1:0][3:0] lo;
    int last;
    if (cmp_en) begin
      model_select(g, lo, last);
      chk("model_issuing", 64'(rs_data_issuing), 64'(g));
      chk("model_valid", 64'(issue_valid), 64'(m_valid));
      for (int k = 0; k < N; k++)
        chk($sformatf("model_packet%0d", k), 64'(issue_packet[k]), 64'(m_pkt[k]));
      chk("model_count", 64'(issued_count), 64'(m_cnt));
    end
  end

  task automatic set_rs(input logic [RS_SZ-1:0] vld, input logic [RS_SZ-1:0] r1,
                        input logic [RS_SZ-1:0] r2);
    rs_valid_issue = vld;
    for (int e = 0; e < RS_SZ; e++) begin
      rs_data_next[e].payload    = 8'h10 + 8'(e);
      rs_data_next[e].b_mask     = bm[e];
      rs_data_next[e].src1_ready = r1[e];
      rs_data_next[e].src2_ready = r2[e];
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    rs_packet_t exp_p;
    for (int e = 0; e < RS_SZ; e++) bm[e] = '0;
    reset = 1'b1; fu_ready = '0; b_mm_resolve = '0; b_mm_mispred = 1'b0;
    set_rs(8'hFF, 8'hFF, 8'hFF);
    cyc(); cyc();
    cmp_en = 1'b1;
    @(negedge clock);
    chk("reset_issuing", 64'(rs_data_issuing), 64'h0);
    chk("reset_valid", 64'(issue_valid), 64'h0);
    chk("reset_count", 64'(issued_count), 64'h0);

    // select: entry 2 is valid but not ready
    cyc(); reset = 1'b0; set_rs(8'b0100_1110, 8'b0100_1010, 8'b0100_1110);
    @(negedge clock);
    chk("sel_issuing", 64'(rs_data_issuing), 64'b0000_1010);
    cyc(); set_rs('0, '0, '0);
    @(negedge clock);
    chk("sel_valid", 64'(issue_valid), 64'b11);
    chk("sel_lane0", 64'(issue_packet[0].payload), 64'h11);
    chk("sel_lane1", 64'(issue_packet[1].payload), 64'h13);

    // rr_ptr is 4 here, so entry 5 is found before entry 0
    cyc(); set_rs(8'b0010_0001, 8'hFF, 8'hFF); fu_ready = 2'b11;
    @(negedge clock);
    chk("ptr_issuing", 64'(rs_data_issuing), 64'b0010_0001);
    cyc(); set_rs(8'b0010_0000, 8'hFF, 8'hFF); fu_ready = 2'b11;
    @(negedge clock);
    chk("ptr_lane0", 64'(issue_packet[0].payload), 64'h15);
    chk("ptr_lane1", 64'(issue_packet[1].payload), 64'h10);
    chk("ptr_count", 64'(issued_count), 64'd2);

    // wrap: rr_ptr is 6, so entry 7 is found before entry 0
    cyc(); set_rs(8'b1000_0001, 8'hFF, 8'hFF); fu_ready = 2'b01;
    @(negedge clock);
    chk("wrap_issuing", 64'(rs_data_issuing), 64'b1000_0001);
    chk("wrap_count", 64'(issued_count), 64'd4);
    cyc(); set_rs('0, '0, '0); fu_ready = 2'b10;
    @(negedge clock);
    chk("wrap_lane0", 64'(issue_packet[0].payload), 64'h17);
    chk("wrap_lane1", 64'(issue_packet[1].payload), 64'h10);
    chk("wrap_count2", 64'(issued_count), 64'd5);

    // stall: lane0 is held while lane1 takes a single entry
    cyc(); set_rs(8'b0000_1100, 8'hFF, 8'hFF); fu_ready = 2'b00;
    @(negedge clock);
    chk("stall_issuing1", 64'(rs_data_issuing), 64'b0000_0100);
    chk("stall_valid1", 64'(issue_valid), 64'b01);
    cyc(); set_rs(8'b0000_1000, 8'hFF, 8'hFF);
    @(negedge clock);
    chk("stall_issuing2", 64'(rs_data_issuing), 64'h0);
    chk("stall_lane1", 64'(issue_packet[1].payload), 64'h12);
    cyc();
    @(negedge clock);
    exp_p = '{payload: 8'h17, b_mask: 4'h0, src1_ready: 1'b1, src2_ready: 1'b1};
    chk("stall_issuing3", 64'(rs_data_issuing), 64'h0);
    chk("stall_lane0_held", 64'(issue_packet[0]), 64'(exp_p));
    cyc(); set_rs('0, '0, '0); fu_ready = 2'b11;
    @(negedge clock);
    cyc(); fu_ready = 2'b00; bm[4] = 4'b0010; bm[5] = 4'b0100;
    set_rs(8'b0011_0000, 8'hFF, 8'hFF);
    @(negedge clock);
    chk("stall_count", 64'(issued_count), 64'd8);
    chk("stall_valid_drained", 64'(issue_valid), 64'b00);
    chk("mp_issuing", 64'(rs_data_issuing), 64'b0011_0000);

    // mispredict: lane0 holds the resolved mask and is squashed
    cyc(); set_rs('0, '0, '0); b_mm_resolve = 4'b0010; b_mm_mispred = 1'b1;
    @(negedge clock);
    chk("mp_valid_pre", 64'(issue_valid), 64'b11);
    cyc(); b_mm_resolve = '0; b_mm_mispred = 1'b0; set_rs(8'b0001_0000, 8'hFF, 8'hFF);
    @(negedge clock);
    chk("mp_valid_post", 64'(issue_valid), 64'b10);
    chk("mp_lane1_mask", 64'(issue_packet[1].b_mask), 64'b0100);
    chk("mp_regrant", 64'(rs_data_issuing), 64'b0001_0000);
    cyc(); set_rs('0, '0, '0); b_mm_resolve = 4'b0010; b_mm_mispred = 1'b0;
    @(negedge clock);
    // same lane squashed and granted in one cycle
    cyc(); b_mm_resolve = 4'b0100; b_mm_mispred = 1'b1; set_rs(8'b0100_0000, 8'hFF, 8'hFF);
    @(negedge clock);
    chk("resolve_mask", 64'(issue_packet[0].b_mask), 64'h0);
    chk("resolve_valid", 64'(issue_valid), 64'b11);
    chk("sqgrant_issuing", 64'(rs_data_issuing), 64'b0100_0000);
    cyc(); b_mm_resolve = '0; b_mm_mispred = 1'b0; set_rs('0, '0, '0);
    @(negedge clock);
    chk("sqgrant_lane1", 64'(issue_packet[1].payload), 64'h16);
    chk("sqgrant_count", 64'(issued_count), 64'd8);

    // reset in the middle of operation
    cyc(); reset = 1'b1; set_rs(8'hFF, 8'hFF, 8'hFF);
    @(negedge clock);
    chk("midreset_issuing", 64'(rs_data_issuing), 64'h0);
    cyc(); reset = 1'b0; set_rs(8'b1000_0010, 8'hFF, 8'hFF);
    @(negedge clock);
    chk("midreset_valid", 64'(issue_valid), 64'b00);
    chk("midreset_count", 64'(issued_count), 64'h0);
    chk("midreset_issuing2", 64'(rs_data_issuing), 64'b1000_0010);
    cyc(); set_rs('0, '0, '0);
    @(negedge clock);
    chk("midreset_lane0", 64'(issue_packet[0].payload), 64'h11);
    chk("midreset_lane1", 64'(issue_packet[1].payload), 64'h17);

    // mixed traffic, checked against the model only
    for (int c = 0; c < 300; c++) begin
      cyc();
      for (int e = 0; e < RS_SZ; e++) bm[e] = 4'($urandom);
      set_rs(8'($urandom), 8'($urandom | $urandom), 8'($urandom | $urandom));
      fu_ready     = 2'($urandom);
      b_mm_resolve = 4'(1 << $urandom_range(0, 3));
      b_mm_mispred = ($urandom_range(0, 7) == 0);
      reset        = ($urandom_range(0, 49) == 0);
    end
    cyc(); reset = 1'b0;
    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
